// File: rtl/ram_scan_reader.sv
// ram_scan_reader: read-side scan master for the registered-input RAM.
// Walks addresses 0..DEPTH-1 and presents each word with its address on a
// valid/ready port. It waits a fixed RD_LAT edges after every address change
// so that the RAM's input flop stage has settled.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no scan in progress, waiting for start
//   WAIT    | address driven, counting down the RAM read latency
//   PRESENT | word captured and offered on the output port
//   DONE    | one-cycle completion pulse after the last word
module ram_scan_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 3,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              cont,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(RD_LAT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAT_LOAD  = CNT_W'(RD_LAT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W-1:0] out_addr_nxt;
    logic [DATA_W-1:0] out_data_nxt;

    // The reader never writes; outputs that are pure state decodes clear
    // together with the state register on reset.
    assign mem_wren  = 1'b0;
    assign out_valid = (state == PRESENT);
    assign busy      = (state == WAIT) || (state == PRESENT);
    assign done      = (state == DONE);

    // State, address, latency counter and presented-word registers.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            mem_addr <= '0;
            out_addr <= '0;
            out_data <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            mem_addr <= addr_nxt;
            out_addr <= out_addr_nxt;
            out_data <= out_data_nxt;
        end
    end

    // Next-state and next-register values; abort wins over an accept.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        addr_nxt     = mem_addr;
        out_addr_nxt = out_addr;
        out_data_nxt = out_data;
        case (state)
            IDLE: begin
                if (start) begin
                    addr_nxt  = '0;
                    cnt_nxt   = LAT_LOAD;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    out_data_nxt = mem_q;
                    out_addr_nxt = mem_addr;
                    state_nxt    = PRESENT;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            PRESENT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (out_ready) begin
                    if (mem_addr != LAST_ADDR) begin
                        addr_nxt  = mem_addr + ADDR_W'(1);
                        cnt_nxt   = LAT_LOAD;
                        state_nxt = WAIT;
                    end else if (cont) begin
                        addr_nxt  = '0;
                        cnt_nxt   = LAT_LOAD;
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed bench for ram_scan_reader: a default-latency instance and an
// RD_LAT=1 instance, each reading a RAM model preloaded with word[k] = k mod 8.
module tb_ram_scan_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, cont, abort, out_ready;
    logic [4:0] mem_addr, out_addr;
    logic       mem_wren, out_valid, busy, done;
    logic [2:0] mem_q, out_data;

    logic       start1, cont1, abort1, out_ready1;
    logic [4:0] mem_addr1, out_addr1;
    logic       mem_wren1, out_valid1, busy1, done1;
    logic [2:0] mem_q1, out_data1;

    int tests = 0;
    int fails = 0;

    logic [2:0] ram [32];
    logic [4:0] a0_d1, a0_d2, a1_d1;

    always #5 clk = ~clk;

    // RAM models: two address flop stages for RD_LAT=2, one for RD_LAT=1.
    always @(posedge clk) begin
        a0_d1 <= mem_addr;
        a0_d2 <= a0_d1;
        a1_d1 <= mem_addr1;
    end
    assign mem_q  = ram[a0_d2];
    assign mem_q1 = ram[a1_d1];

    ram_scan_reader #(.ADDR_W(5), .DATA_W(3), .DEPTH(32), .RD_LAT(2)) u_dut (
        .clk(clk), .Reset_n(rst_n), .start(start), .cont(cont), .abort(abort),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_q(mem_q),
        .out_addr(out_addr), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    ram_scan_reader #(.ADDR_W(5), .DATA_W(3), .DEPTH(32), .RD_LAT(1)) u_dut1 (
        .clk(clk), .Reset_n(rst_n), .start(start1), .cont(cont1), .abort(abort1),
        .mem_addr(mem_addr1), .mem_wren(mem_wren1), .mem_q(mem_q1),
        .out_addr(out_addr1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready1), .busy(busy1), .done(done1)
    );

    // Wait (bounded) for the default instance to present a given address.
    task automatic wait_addr(input logic [4:0] target, input int max, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < max && !ok; n++) begin
            @(negedge clk);
            if (out_valid && out_addr == target) ok = 1'b1;
        end
    endtask

    // Wait (bounded) for the default instance to raise out_valid.
    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < max && !ok; n++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_addr !== 5'd0 ||
            out_addr !== 5'd0 || out_data !== 3'd0 || mem_wren !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b mem_addr=%0d out_addr=%0d out_data=%0d wren=%b, want all 0",
                     out_valid, busy, done, mem_addr, out_addr, out_data, mem_wren);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b valid=%b, want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_full_scan();
        int first = -1, last_valid = -1, accepts = 0, done_cnt = 0, done_at = -1;
        bit wren_bad = 0;
        logic [4:0] exp_addr = 5'd0;
        logic [2:0] data9 = 3'bx, data31 = 3'bx;
        out_ready = 1'b1;
        cont = 1'b0;
        pulse_start();
        tests++;
        if (busy !== 1'b1 || mem_addr !== 5'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL scan_e0: busy=%b mem_addr=%0d valid=%b, want 1 0 0", busy, mem_addr, out_valid);
        end
        for (int i = 1; i <= 140; i++) begin
            @(negedge clk);
            if (mem_wren !== 1'b0) wren_bad = 1;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = i;
            end
            if (out_valid === 1'b1) begin
                if (first < 0) first = i;
                last_valid = i;
                tests++;
                if (out_addr !== exp_addr || out_data !== exp_addr[2:0]) begin
                    fails++;
                    $display("FAIL scan_word: got addr=%0d data=%0d, want addr=%0d data=%0d",
                             out_addr, out_data, exp_addr, exp_addr[2:0]);
                end
                if (out_addr == 5'd9)  data9  = out_data;
                if (out_addr == 5'd31) data31 = out_data;
                accepts++;
                exp_addr = exp_addr + 5'd1;
            end
        end
        tests++;
        if (first !== 3) begin
            fails++;
            $display("FAIL scan_first_valid: got cycle %0d, want 3", first);
        end
        tests++;
        if (data9 !== 3'd1 || data31 !== 3'd7) begin
            fails++;
            $display("FAIL scan_data_9_31: got %0d %0d, want 1 7", data9, data31);
        end
        tests++;
        if (accepts !== 32) begin
            fails++;
            $display("FAIL scan_accepts: got %0d, want 32", accepts);
        end
        tests++;
        if (last_valid !== 127) begin
            fails++;
            $display("FAIL scan_last_word_cycle: got %0d, want 127", last_valid);
        end
        tests++;
        if (done_cnt !== 1 || done_at !== 128) begin
            fails++;
            $display("FAIL scan_done: got count=%0d at=%0d, want count=1 at=128", done_cnt, done_at);
        end
        tests++;
        if (wren_bad !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL scan_wren_busy: wren_seen=%b busy=%b, want 0 0", wren_bad, busy);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        out_ready = 1'b1;
        pulse_start();
        wait_addr(5'd4, 40, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL bp_reach_4: address 4 not presented, got %b want 1", ok);
        end
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || out_addr !== 5'd4 || out_data !== 3'd4 || mem_addr !== 5'd4) begin
                fails++;
                $display("FAIL bp_hold: got valid=%b addr=%0d data=%0d mem_addr=%0d, want 1 4 4 4",
                         out_valid, out_addr, out_data, mem_addr);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || mem_addr !== 5'd5) begin
            fails++;
            $display("FAIL bp_release: got valid=%b mem_addr=%0d, want 0 5", out_valid, mem_addr);
        end
        wait_valid(10, ok);
        tests++;
        if (!ok || out_addr !== 5'd5 || out_data !== 3'd5) begin
            fails++;
            $display("FAIL bp_next_word: got ok=%b addr=%0d data=%0d, want 1 5 5", ok, out_addr, out_data);
        end
        do_abort();
    endtask

    task automatic test_continuous();
        bit ok, found = 0, busy_low = 0, done_seen = 0;
        out_ready = 1'b1;
        cont = 1'b0;
        pulse_start();
        wait_addr(5'd31, 200, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL cont_reach_31: address 31 not presented, got %b want 1", ok);
        end
        cont = 1'b1;
        for (int n = 0; n < 8 && !found; n++) begin
            @(negedge clk);
            cont = 1'b0;
            if (busy !== 1'b1) busy_low = 1;
            if (done === 1'b1) done_seen = 1;
            if (out_valid === 1'b1) found = 1;
        end
        tests++;
        if (!found || out_addr !== 5'd0 || out_data !== 3'd0) begin
            fails++;
            $display("FAIL cont_wrap_word: got found=%b addr=%0d data=%0d, want 1 0 0", found, out_addr, out_data);
        end
        tests++;
        if (busy_low !== 1'b0 || done_seen !== 1'b0) begin
            fails++;
            $display("FAIL cont_no_done: got busy_low=%b done=%b, want 0 0", busy_low, done_seen);
        end
        do_abort();
    endtask

    task automatic test_abort();
        bit ok, done_seen = 0;
        out_ready = 1'b1;
        pulse_start();
        wait_addr(5'd3, 40, ok);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(10, ok);
        tests++;
        if (!ok || out_addr !== 5'd4) begin
            fails++;
            $display("FAIL abort_start_ignored: got ok=%b addr=%0d, want 1 4", ok, out_addr);
        end
        wait_addr(5'd9, 40, ok);
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || mem_addr !== 5'd10) begin
            fails++;
            $display("FAIL abort_in_wait: got busy=%b valid=%b mem_addr=%0d, want 1 0 10", busy, out_valid, mem_addr);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || mem_addr !== 5'd10) begin
            fails++;
            $display("FAIL abort_result: got busy=%b valid=%b done=%b mem_addr=%0d, want 0 0 0 10",
                     busy, out_valid, done, mem_addr);
        end
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen = 1;
        end
        tests++;
        if (done_seen !== 1'b0) begin
            fails++;
            $display("FAIL abort_quiet: got done/busy activity=%b, want 0", done_seen);
        end
        pulse_start();
        repeat (3) @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_addr !== 5'd0 || out_data !== 3'd0) begin
            fails++;
            $display("FAIL abort_rescan: got valid=%b addr=%0d data=%0d, want 1 0 0", out_valid, out_addr, out_data);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || mem_addr !== 5'd0) begin
            fails++;
            $display("FAIL abort_priority: got busy=%b valid=%b mem_addr=%0d, want 0 0 0", busy, out_valid, mem_addr);
        end
    endtask

    task automatic test_latency();
        int first = -1, second = -1, words = 0;
        logic [4:0] exp_addr = 5'd0;
        out_ready1 = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (out_valid1 === 1'b1) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
                words++;
                tests++;
                if (out_addr1 !== exp_addr || out_data1 !== exp_addr[2:0]) begin
                    fails++;
                    $display("FAIL lat1_word: got addr=%0d data=%0d, want addr=%0d data=%0d",
                             out_addr1, out_data1, exp_addr, exp_addr[2:0]);
                end
                exp_addr = exp_addr + 5'd1;
            end
        end
        tests++;
        if (first !== 2 || second !== 5 || words !== 3) begin
            fails++;
            $display("FAIL lat1_timing: got first=%0d second=%0d words=%0d, want 2 5 3", first, second, words);
        end
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok, active = 0;
        out_ready = 1'b1;
        pulse_start();
        wait_addr(5'd7, 40, ok);
        out_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (!ok || out_valid !== 1'b1 || mem_addr !== 5'd7) begin
            fails++;
            $display("FAIL rstmid_setup: got ok=%b valid=%b mem_addr=%0d, want 1 1 7", ok, out_valid, mem_addr);
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_addr !== 5'd0 || out_addr !== 5'd0) begin
            fails++;
            $display("FAIL rstmid_async: got valid=%b busy=%b done=%b mem_addr=%0d out_addr=%0d, want all 0",
                     out_valid, busy, done, mem_addr, out_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (busy === 1'b1 || out_valid === 1'b1 || done === 1'b1) active = 1;
        end
        tests++;
        if (active !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_stays_idle: got activity=%b, want 0", active);
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) ram[k] = 3'(k % 8);
        start = 0; cont = 0; abort = 0; out_ready = 1;
        start1 = 0; cont1 = 0; abort1 = 0; out_ready1 = 1;
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_full_scan();
        test_backpressure();
        test_continuous();
        test_abort();
        test_latency();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
